// File: rtl/mpll_lock_detect_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mpll_lock_detect_pkg: shared PLL lock-detect encodings/defaults   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package mpll_lock_detect_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_HOLD     = 2'd3
  } lock_state_e;

  // 155.52 MHz VCXO / 80 kHz compare rate
  localparam int DEF_WINDOW         = 1944;
  localparam int DEF_WIN_W          = 11;
  localparam int DEF_ERR_THRESH     = 8;
  localparam int DEF_LOCK_WINDOWS   = 64;
  localparam int DEF_UNLOCK_WINDOWS = 4;
  localparam int DEF_CNT_W          = 8;

  // Signed per-clock phase contribution: +1 pump up, -1 pump down, 0 idle
  function automatic logic signed [1:0] pfd_step(input logic en, input logic pol);
    if (!en) return 2'sd0;
    return pol ? 2'sd1 : -2'sd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mpll_lock_detect_pfd_sample_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pfd_sample_sync: 2-flop synchronizer for the PFD {pol,enable} pair|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module pfd_sample_sync #(
  parameter int WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/mpll_lock_detect.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mpll_lock_detect: windowed PFD error qualifier and lock FSM       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module mpll_lock_detect
  import mpll_lock_detect_pkg::*;
#(
  parameter int WINDOW         = DEF_WINDOW,
  parameter int WIN_W          = DEF_WIN_W,
  parameter int ERR_THRESH     = DEF_ERR_THRESH,
  parameter int LOCK_WINDOWS   = DEF_LOCK_WINDOWS,
  parameter int UNLOCK_WINDOWS = DEF_UNLOCK_WINDOWS,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_pol,
  input  logic                    i_enable,
  input  logic                    i_clear_lost,
  output logic                    o_locked,
  output logic [1:0]              o_lock_state,
  output logic                    o_lost,
  output logic                    o_err_valid,
  output logic signed [WIN_W:0]   o_err_sum,
  output logic [WIN_W-1:0]        o_err_count
);

  logic [1:0]            w_sync;
  logic                  w_smp_en;
  logic                  w_smp_pol;
  logic signed [1:0]     w_step;
  logic [WIN_W:0]        w_step_ext;
  logic                  w_win_end;
  logic [WIN_W-1:0]      w_tot_cnt;
  logic signed [WIN_W:0] w_tot_sum;
  logic                  w_good;

  logic [WIN_W-1:0]      r_wcnt;
  logic [WIN_W-1:0]      r_acc_cnt;
  logic signed [WIN_W:0] r_acc_sum;
  logic                  r_err_valid;
  logic [WIN_W-1:0]      r_err_count;
  logic signed [WIN_W:0] r_err_sum;

  lock_state_e           r_state;
  lock_state_e           w_state_nxt;
  logic [CNT_W-1:0]      r_run;
  logic [CNT_W-1:0]      w_run_nxt;
  logic [CNT_W-1:0]      w_run_inc;
  logic                  w_lost_set;
  logic                  w_lost_nxt;
  logic                  r_lost;
  logic                  r_locked;

  pfd_sample_sync #(
    .WIDTH (2)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async ({i_pol, i_enable}),
    .o_sync  (w_sync)
  );

  assign w_smp_pol  = w_sync[1];
  assign w_smp_en   = w_sync[0];
  assign w_step     = pfd_step(w_smp_en, w_smp_pol);
  assign w_step_ext = {{(WIN_W-1){w_step[1]}}, w_step};

  // Totals include the current sample so the window-end cycle is never lost
  assign w_win_end = (r_wcnt == WIN_W'(WINDOW - 1));
  assign w_tot_cnt = r_acc_cnt + {{(WIN_W-1){1'b0}}, w_smp_en};
  assign w_tot_sum = r_acc_sum + w_step_ext;
  assign w_good    = (w_tot_cnt <= WIN_W'(ERR_THRESH));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wcnt      <= '0;
      r_acc_cnt   <= '0;
      r_acc_sum   <= '0;
      r_err_valid <= 1'b0;
      r_err_count <= '0;
      r_err_sum   <= '0;
    end else begin
      r_err_valid <= w_win_end;
      if (w_win_end) begin
        r_wcnt      <= '0;
        r_acc_cnt   <= '0;
        r_acc_sum   <= '0;
        r_err_count <= w_tot_cnt;
        r_err_sum   <= w_tot_sum;
      end else begin
        r_wcnt      <= r_wcnt + WIN_W'(1);
        r_acc_cnt   <= w_tot_cnt;
        r_acc_sum   <= w_tot_sum;
      end
    end
  end

  assign w_run_inc = r_run + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_lost_set  = 1'b0;
    if (w_win_end) begin
      case (r_state)
        ST_UNLOCKED: begin
          if (w_good) begin
            w_state_nxt = ST_ACQUIRE;
            w_run_nxt   = CNT_W'(1);
          end else begin
            w_run_nxt   = '0;
          end
        end
        ST_ACQUIRE: begin
          if (!w_good) begin
            w_state_nxt = ST_UNLOCKED;
            w_run_nxt   = '0;
          end else if (w_run_inc == CNT_W'(LOCK_WINDOWS)) begin
            w_state_nxt = ST_LOCKED;
            w_run_nxt   = '0;
          end else begin
            w_run_nxt   = w_run_inc;
          end
        end
        ST_LOCKED: begin
          if (!w_good) begin
            if (UNLOCK_WINDOWS == 1) begin
              w_state_nxt = ST_UNLOCKED;
              w_run_nxt   = '0;
              w_lost_set  = 1'b1;
            end else begin
              w_state_nxt = ST_HOLD;
              w_run_nxt   = CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (w_good) begin
            w_state_nxt = ST_LOCKED;
            w_run_nxt   = '0;
          end else if (w_run_inc == CNT_W'(UNLOCK_WINDOWS)) begin
            w_state_nxt = ST_UNLOCKED;
            w_run_nxt   = '0;
            w_lost_set  = 1'b1;
          end else begin
            w_run_nxt   = w_run_inc;
          end
        end
        default: begin
          w_state_nxt = ST_UNLOCKED;
          w_run_nxt   = '0;
        end
      endcase
    end
  end

  // A new loss event outranks a coincident clear request
  assign w_lost_nxt = w_lost_set ? 1'b1 : (i_clear_lost ? 1'b0 : r_lost);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_UNLOCKED;
      r_run    <= '0;
      r_lost   <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_run    <= w_run_nxt;
      r_lost   <= w_lost_nxt;
      r_locked <= (w_state_nxt == ST_LOCKED) || (w_state_nxt == ST_HOLD);
    end
  end

  assign o_locked     = r_locked;
  assign o_lock_state = r_state;
  assign o_lost       = r_lost;
  assign o_err_valid  = r_err_valid;
  assign o_err_count  = r_err_count;
  assign o_err_sum    = r_err_sum;

endmodule
`default_nettype wire

// File: tb/tb_mpll_lock_detect.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mpll_lock_detect: window-table, corner and random checks       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_mpll_lock_detect;

  localparam int WIN   = 16;
  localparam int WW    = 5;
  localparam int THR   = 2;
  localparam int LOCKN = 4;
  localparam int UNLN  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pol = 1'b0;
  logic en  = 1'b0;
  logic clr = 1'b0;
  logic              locked;
  logic [1:0]        lock_state;
  logic              lost;
  logic              err_valid;
  logic signed [WW:0] err_sum;
  logic [WW-1:0]     err_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mpll_lock_detect #(
    .WINDOW(WIN), .WIN_W(WW), .ERR_THRESH(THR),
    .LOCK_WINDOWS(LOCKN), .UNLOCK_WINDOWS(UNLN), .CNT_W(3)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_pol(pol), .i_enable(en), .i_clear_lost(clr),
    .o_locked(locked), .o_lock_state(lock_state), .o_lost(lost),
    .o_err_valid(err_valid), .o_err_sum(err_sum), .o_err_count(err_count)
  );

  // Reference model: 2-clock input delay line, window totals, lock rules
  bit [1:0] sq[$];
  int m_wc, m_cnt, m_sum, m_state, m_run, m_ecnt, m_esum;
  bit m_lost, m_valid;
  int cyc = 0;

  task automatic model_reset();
    sq = {2'b00, 2'b00};
    m_wc = 0; m_cnt = 0; m_sum = 0; m_state = 0; m_run = 0;
    m_ecnt = 0; m_esum = 0; m_lost = 0; m_valid = 0;
  endtask

  task automatic model_edge(input bit p, input bit e, input bit c);
    bit [1:0] s;
    bit good, set;
    s = sq.pop_front();
    sq.push_back({p, e});
    set = 0;
    m_valid = 0;
    if (s[0]) begin
      m_cnt += 1;
      m_sum += s[1] ? 1 : -1;
    end
    if (m_wc == WIN - 1) begin
      m_valid = 1; m_ecnt = m_cnt; m_esum = m_sum;
      good = (m_cnt <= THR);
      case (m_state)
        0: if (good) begin m_state = 1; m_run = 1; end else m_run = 0;
        1: if (!good) begin m_state = 0; m_run = 0; end
           else if (m_run + 1 == LOCKN) begin m_state = 2; m_run = 0; end
           else m_run += 1;
        2: if (!good) begin m_state = 3; m_run = 1; end
        default: if (good) begin m_state = 2; m_run = 0; end
           else if (m_run + 1 == UNLN) begin m_state = 0; m_run = 0; set = 1; end
           else m_run += 1;
      endcase
      m_cnt = 0; m_sum = 0; m_wc = 0;
    end else begin
      m_wc += 1;
    end
    if (set) m_lost = 1;
    else if (c) m_lost = 0;
  endtask

  task automatic step(input bit p, input bit e, input bit c);
    logic signed [WW:0] xs;
    pol = p; en = e; clr = c;
    @(posedge clk);
    model_edge(p, e, c);
    cyc++;
    #1;
    xs = (WW+1)'(m_esum);
    tests++;
    if (lock_state !== 2'(m_state) || locked !== (m_state >= 2) || lost !== m_lost ||
        err_valid !== m_valid || err_count !== WW'(m_ecnt) || err_sum !== xs) begin
      fails++;
      $display("FAIL model cyc=%0d got st=%0d lk=%0b lost=%0b v=%0b cnt=%0d sum=%0d want st=%0d lk=%0b lost=%0b v=%0b cnt=%0d sum=%0d",
               cyc, lock_state, locked, lost, err_valid, err_count, err_sum,
               m_state, m_state >= 2, m_lost, m_valid, m_ecnt, m_esum);
    end
  endtask

  typedef struct {
    int n; bit p; int clr_at;
    int st; bit lst; int cnt; int sum;
  } win_vec_t;

  win_vec_t tbl[23];

  initial begin
    logic signed [WW:0] xs;
    bit e;
    int k;
    // {enable clocks, pol, clear cycle, exp state, exp lost, exp count, exp sum}
    tbl[0]  = '{0, 0, -1, 1, 0, 0, 0};
    tbl[1]  = '{0, 0, -1, 1, 0, 0, 0};
    tbl[2]  = '{2, 1, -1, 1, 0, 2, 2};
    tbl[3]  = '{0, 0, -1, 2, 0, 0, 0};
    tbl[4]  = '{16, 1, -1, 3, 0, 14, 14};
    tbl[5]  = '{16, 1, -1, 0, 1, 16, 16};
    tbl[6]  = '{0, 0, -1, 1, 1, 2, 2};
    tbl[7]  = '{0, 0, 5, 1, 0, 0, 0};
    tbl[8]  = '{0, 0, -1, 1, 0, 0, 0};
    tbl[9]  = '{3, 0, -1, 0, 0, 3, -3};
    tbl[10] = '{0, 0, -1, 1, 0, 0, 0};
    tbl[11] = '{0, 0, -1, 1, 0, 0, 0};
    tbl[12] = '{0, 0, -1, 1, 0, 0, 0};
    tbl[13] = '{0, 0, -1, 2, 0, 0, 0};
    tbl[14] = '{16, 0, -1, 3, 0, 14, -14};
    tbl[15] = '{0, 0, -1, 2, 0, 2, -2};
    tbl[16] = '{16, 1, -1, 3, 0, 14, 14};
    tbl[17] = '{16, 1, 15, 0, 1, 16, 16};
    tbl[18] = '{0, 0, -1, 1, 1, 2, 2};
    tbl[19] = '{0, 0, -1, 1, 1, 0, 0};
    tbl[20] = '{0, 0, -1, 1, 1, 0, 0};
    tbl[21] = '{0, 0, -1, 2, 1, 0, 0};
    tbl[22] = '{0, 0, -1, 2, 1, 0, 0};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (lock_state !== 0 || locked !== 0 || lost !== 0 || err_valid !== 0 ||
        err_count !== 0 || err_sum !== 0) begin
      fails++;
      $display("FAIL reset_state got st=%0d lk=%0b lost=%0b v=%0b cnt=%0d sum=%0d want all 0",
               lock_state, locked, lost, err_valid, err_count, err_sum);
    end
    rst = 1'b0;

    for (int w = 0; w < 23; w++) begin
      for (int i = 0; i < WIN; i++) begin
        e = (tbl[w].n == WIN) ? 1'b1 : (i >= 4 && i < 4 + tbl[w].n);
        step(tbl[w].p, e, i == tbl[w].clr_at);
      end
      xs = (WW+1)'(tbl[w].sum);
      tests++;
      if (err_valid !== 1'b1 || lock_state !== 2'(tbl[w].st) || lost !== tbl[w].lst ||
          locked !== (tbl[w].st >= 2) || err_count !== WW'(tbl[w].cnt) || err_sum !== xs) begin
        fails++;
        $display("FAIL window%0d got v=%0b st=%0d lost=%0b lk=%0b cnt=%0d sum=%0d want v=1 st=%0d lost=%0b cnt=%0d sum=%0d",
                 w, err_valid, lock_state, lost, locked, err_count, err_sum,
                 tbl[w].st, tbl[w].lst, tbl[w].cnt, tbl[w].sum);
      end
    end

    // Async reset at wcnt=7 while locked with a partial window accumulating
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (lock_state !== 0 || locked !== 0 || lost !== 0 || err_valid !== 0 ||
        err_count !== 0 || err_sum !== 0) begin
      fails++;
      $display("FAIL async_reset got st=%0d lk=%0b lost=%0b v=%0b cnt=%0d sum=%0d want all 0",
               lock_state, locked, lost, err_valid, err_count, err_sum);
    end
    model_reset();
    pol = 0; en = 0; clr = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    k = 0;
    while (k < 40) begin
      step(1'b0, 1'b0, 1'b0);
      k++;
      if (err_valid) break;
    end
    tests++;
    if (k != WIN || err_count !== 0 || err_sum !== 0) begin
      fails++;
      $display("FAIL first_valid_after_reset got clocks=%0d cnt=%0d sum=%0d want clocks=%0d cnt=0 sum=0",
               k, err_count, err_sum, WIN);
    end

    // Randomized windows: quiet or noisy, occasional clear pulses
    for (int w = 0; w < 40; w++) begin
      bit noisy;
      noisy = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < WIN; i++) begin
        e = noisy ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 31) == 0);
        step(1'($urandom_range(0, 1)), e, $urandom_range(0, 63) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
